shift_right_seq: RTL and testbench

- Multi-cycle right-shift unit, the counterpart of the existing single-step left-shift datapath block.
- Accepts a WIDTH-bit operand and a shift amount, then shifts right one bit per clock, logical or arithmetic.
- Sits beside the ALU and serves SRL/SRA/SRLV/SRAV; the decode stage stalls on busy_o.

---
 rtl/shift_pkg.sv | 22 ++
 rtl/shift_right_step.sv | 29 ++
 rtl/shift_right_seq.sv | 114 +++++++++++
 tb/tb_shift_right_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// ============================================================================
// Module   : shift_pkg
// Purpose  : Shared types and constants for the multi-cycle right shifter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    localparam int DEFAULT_WIDTH   = 32;
    localparam int DEFAULT_SHAMT_W = 5;
    localparam int FAST4_STEP      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_right_step.sv
// ============================================================================
// Module   : shift_right_step
// Purpose  : Combinational right shift by 1 or by FAST4_STEP with sign fill.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_right_step
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] work_i,
    input  logic             fill_i,
    input  logic             step4_i,
    output logic [WIDTH-1:0] shifted_o
);

    always_comb begin
        if (step4_i) begin
            shifted_o = {{FAST4_STEP{fill_i}}, work_i[WIDTH-1:FAST4_STEP]};
        end else begin
            shifted_o = {fill_i, work_i[WIDTH-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/shift_right_seq.sv
// ============================================================================
// Module   : shift_right_seq
// Purpose  : Multi-cycle logical/arithmetic right shifter (SRL/SRA family).
//            Define SHIFT_RIGHT_FAST4_EN to retire 4 bits per cycle when able.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_right_seq
    import shift_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SHAMT_W = DEFAULT_SHAMT_W   // must equal $clog2(WIDTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               arith_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   data_o
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q,  work_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic               sign_q,  sign_d;
    logic               arith_q, arith_d;
    logic [WIDTH-1:0]   data_q,  data_d;

    logic               step4;
    logic [SHAMT_W-1:0] dec;
    logic [WIDTH-1:0]   shifted;

`ifdef SHIFT_RIGHT_FAST4_EN
    assign step4 = (count_q >= SHAMT_W'(FAST4_STEP));
`else
    assign step4 = 1'b0;
`endif

    assign dec = step4 ? SHAMT_W'(FAST4_STEP) : SHAMT_W'(1);

    // Fill bit is the captured MSB only in arithmetic mode.
    shift_right_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .work_i    (work_q),
        .fill_i    (sign_q & arith_q),
        .step4_i   (step4),
        .shifted_o (shifted)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        sign_d  = sign_q;
        arith_d = arith_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    work_d  = data_i;
                    count_d = shamt_i;
                    sign_d  = data_i[WIDTH-1];
                    arith_d = arith_i;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (count_q != '0) begin
                    work_d  = shifted;
                    count_d = count_q - dec;
                end else begin
                    data_d  = work_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            work_q  <= '0;
            count_q <= '0;
            sign_q  <= 1'b0;
            arith_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
            sign_q  <= sign_d;
            arith_q <= arith_d;
            data_q  <= data_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);
    assign data_o = data_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_right_seq.sv
// ============================================================================
// Module   : tb_shift_right_seq
// Purpose  : Directed self-checking bench for shift_right_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_right_seq;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] data_i = '0;
    logic [4:0]  shamt_i = '0;
    logic        arith_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] data_o;

    int tests = 0;
    int fails = 0;

    shift_right_seq #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .data_i  (data_i),
        .shamt_i (shamt_i),
        .arith_i (arith_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .data_o  (data_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int exp_lat(input int s);
`ifdef SHIFT_RIGHT_FAST4_EN
        return s / 4 + s % 4 + 2;
`else
        return s + 2;
`endif
    endfunction

    // Issues one operation; lat counts rising edges from the start cycle to done_o.
    task automatic do_op(input logic [31:0] d, input logic [4:0] s, input logic a,
                         output logic [31:0] res, output int lat,
                         output int idle_gaps, output bit timeout);
        res = '0;
        lat = 0;
        idle_gaps = 0;
        timeout = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b1; data_i = d; shamt_i = s; arith_i = a;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
            data_i  = $urandom;
            shamt_i = 5'($urandom);
            arith_i = 1'($urandom);
            lat++;
            @(negedge clk_i);
            if (!busy_o) idle_gaps++;
            if (done_o) begin
                res = data_o;
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic check_op(input string name, input logic [31:0] d, input logic [4:0] s,
                            input logic a, input logic [31:0] exp);
        logic [31:0] res;
        int lat, gaps;
        bit to;
        do_op(d, s, a, res, lat, gaps, to);
        tests++;
        if (to) begin
            fails++;
            $display("FAIL %s timeout: no done_o within 60 cycles", name);
        end
        tests++;
        if (res !== exp) begin
            fails++;
            $display("FAIL %s result: got %h expected %h", name, res, exp);
        end
        tests++;
        if (lat !== exp_lat(int'(s))) begin
            fails++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat(int'(s)));
        end
        tests++;
        if (gaps !== 0) begin
            fails++;
            $display("FAIL %s busy: dropped %0d times before done, expected 0", name, gaps);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        tests++;
        if (busy_o !== 1'b0) begin fails++; $display("FAIL reset busy: got %b expected 0", busy_o); end
        tests++;
        if (done_o !== 1'b0) begin fails++; $display("FAIL reset done: got %b expected 0", done_o); end
        tests++;
        if (data_o !== 32'h0) begin fails++; $display("FAIL reset data: got %h expected 0", data_o); end
        rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_logical();
        check_op("logical", 32'h8000_00F0, 5'd4, 1'b0, 32'h0800_000F);
        check_op("logical_s8", 32'hF000_0000, 5'd8, 1'b0, 32'h00F0_0000);
        check_op("logical_s9", 32'h8000_0000, 5'd9, 1'b0, 32'h0040_0000);
    endtask

    task automatic test_arith();
        check_op("arith", 32'h8000_00F0, 5'd4, 1'b1, 32'hF800_000F);
        check_op("arith_s8", 32'hF000_0000, 5'd8, 1'b1, 32'hFFF0_0000);
        check_op("arith_pos", 32'h1234_5678, 5'd12, 1'b1, 32'h0001_2345);
        check_op("arith_s16", 32'h8765_4321, 5'd16, 1'b1, 32'hFFFF_8765);
    endtask

    task automatic test_boundaries();
        check_op("shamt0", 32'hDEAD_BEEF, 5'd0, 1'b1, 32'hDEAD_BEEF);
        check_op("shamt31_arith", 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF);
        check_op("shamt31_logic", 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001);
    endtask

    task automatic test_hold();
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        tests++;
        if (data_o !== 32'h0000_0001) begin
            fails++;
            $display("FAIL hold: data_o got %h expected 00000001", data_o);
        end
    endtask

    task automatic test_model();
        logic [31:0] d, res, exp;
        logic [4:0]  s;
        logic        a;
        int lat, gaps;
        bit to;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            s = 5'($urandom);
            a = 1'($urandom);
            exp = a ? 32'($signed(d) >>> s) : (d >> s);
            do_op(d, s, a, res, lat, gaps, to);
            tests++;
            if (to || res !== exp || lat != exp_lat(int'(s))) begin
                fails++;
                $display("FAIL model d=%h s=%0d a=%b: got %h lat %0d expected %h lat %0d",
                         d, s, a, res, lat, exp, exp_lat(int'(s)));
            end
        end
    endtask

    task automatic test_back_to_back();
        int dones, overlap, first_done, idle_at;
        bit busy_after_idle;
        dones = 0; overlap = 0; first_done = -1; idle_at = -1; busy_after_idle = 1'b0;
        @(posedge clk_i); #1;
        start_i = 1'b1; data_i = 32'hF000_00F0; shamt_i = 5'd3; arith_i = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (done_o) begin dones++; if (first_done < 0) first_done = k; end
            if (done_o && !busy_o) overlap++;
            if (!busy_o && idle_at < 0) idle_at = k;
            if (idle_at > 0 && k == idle_at + 1 && busy_o) busy_after_idle = 1'b1;
        end
        tests++;
        if (dones !== 1) begin fails++; $display("FAIL collision dones: got %0d expected 1", dones); end
        tests++;
        if (first_done !== 5) begin fails++; $display("FAIL collision done edge: got %0d expected 5", first_done); end
        tests++;
        if (idle_at !== 6) begin fails++; $display("FAIL collision idle edge: got %0d expected 6", idle_at); end
        tests++;
        if (!busy_after_idle) begin fails++; $display("FAIL collision reaccept: got 0 expected busy after idle"); end
        tests++;
        if (overlap !== 0) begin fails++; $display("FAIL collision overlap: got %0d expected 0", overlap); end
        #1 start_i = 1'b0;
        dones = 0;
        for (int k = 0; k < 20 && dones == 0; k++) begin
            @(negedge clk_i);
            if (done_o) begin
                dones++;
                tests++;
                if (data_o !== 32'hFE00_001E) begin
                    fails++;
                    $display("FAIL collision second result: got %h expected fe00001e", data_o);
                end
            end
        end
        tests++;
        if (dones !== 1) begin fails++; $display("FAIL collision second done: got %0d expected 1", dones); end
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        @(posedge clk_i); #1;
        start_i = 1'b1; data_i = 32'hFFFF_0000; shamt_i = 5'd20; arith_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
        @(posedge clk_i); #3;
        rst_i = 1'b1;
        #1;
        tests++;
        if (busy_o !== 1'b0) begin fails++; $display("FAIL midreset busy: got %b expected 0", busy_o); end
        tests++;
        if (data_o !== 32'h0) begin fails++; $display("FAIL midreset data: got %h expected 0", data_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_i);
            if (done_o) dones++;
        end
        tests++;
        if (dones !== 0) begin fails++; $display("FAIL midreset done: got %0d pulses expected 0", dones); end
        check_op("after_reset", 32'h8000_00F0, 5'd4, 1'b1, 32'hF800_000F);
    endtask

    initial begin
        test_reset();
        test_logical();
        test_arith();
        test_boundaries();
        test_hold();
        test_model();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
